// File: rtl/rab_lookup_arbiter.sv
// rab_lookup_arbiter
//
// Sequences the shared RAB lookup stage between the read (port1, AR) and write
// (port2, AW) slave address ports. One lookup is launched at a time and the port
// selection is held until the stage reports the request as sent. Contention is
// resolved by weighted round-robin: port1 may win up to PORT1_WEIGHT consecutive
// launches before port2 takes priority. Per-port launch counters and a sticky
// timeout flag are exported for debug / config readback.
//
// Ports:
//   Clk_CI, Rst_RBI          clock, asynchronous active-low reset
//   port1/2_addr_valid_i     address pending lookup on port1 / port2
//   port1/2_sent_i           lookup stage forwarded or dropped the request
//   invalidate_i             TLB invalidation running; blocks new launches
//   clear_i                  synchronous clear of counters and timeout flag
//   select_o                 port select to lookup stage (1 = port1, 0 = port2)
//   launch_o                 single-cycle pulse when a lookup is launched
//   busy_o                   a lookup is in flight
//   timeout_o                sticky: a lookup has been busy TIMEOUT_CYCLES cycles
//   port1/2_cnt_o            saturating launch counters

module rab_lookup_arbiter #(
  parameter int unsigned PORT1_WEIGHT   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 port1_addr_valid_i,
  input  logic                 port2_addr_valid_i,
  input  logic                 port1_sent_i,
  input  logic                 port2_sent_i,
  input  logic                 invalidate_i,
  input  logic                 clear_i,
  output logic                 select_o,
  output logic                 launch_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] port1_cnt_o,
  output logic [CNT_WIDTH-1:0] port2_cnt_o
);

  // Busy counter is one value wider than needed so that, once saturated, it
  // can never equal the trigger value again and re-raise a cleared flag.
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ToW-1:0] ToLast = (TIMEOUT_CYCLES == 0) ? '0 : ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] Weight = 4'(PORT1_WEIGHT);

  typedef enum logic [1:0] {
    StIdle = 2'b01,
    StBusy = 2'b10
  } state_e;

  state_e               state_d, state_q;
  logic                 sel_d, sel_q;
  logic [3:0]           burst_d, burst_q;
  logic [ToW-1:0]       busy_cnt_d, busy_cnt_q;
  logic                 timeout_d, timeout_q;
  logic [CNT_WIDTH-1:0] p1_cnt_d, p1_cnt_q;
  logic [CNT_WIDTH-1:0] p2_cnt_d, p2_cnt_q;
  logic                 grant_p1;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    burst_d    = burst_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    p1_cnt_d   = p1_cnt_q;
    p2_cnt_d   = p2_cnt_q;
    grant_p1   = 1'b1;
    select_o   = 1'b1;
    launch_o   = 1'b0;
    busy_o     = 1'b0;

    case (state_q)
      StIdle: begin
        // Port1 is the default when idle or when it still has burst credit.
        if (port1_addr_valid_i && port2_addr_valid_i) begin
          grant_p1 = (burst_q < Weight);
        end else if (port2_addr_valid_i) begin
          grant_p1 = 1'b0;
        end else begin
          grant_p1 = 1'b1;
        end
        select_o = grant_p1;
        launch_o = ~invalidate_i & (port1_addr_valid_i | port2_addr_valid_i);

        if (launch_o) begin
          sel_d      = grant_p1;
          state_d    = StBusy;
          busy_cnt_d = '0;
          if (grant_p1) begin
            if (p1_cnt_q != '1) p1_cnt_d = p1_cnt_q + CNT_WIDTH'(1);
            if (burst_q < Weight) burst_d = burst_q + 4'd1;
          end else begin
            if (p2_cnt_q != '1) p2_cnt_d = p2_cnt_q + CNT_WIDTH'(1);
            burst_d = '0;
          end
        end
      end

      StBusy: begin
        select_o = sel_q;
        busy_o   = 1'b1;
        if (busy_cnt_q != '1) busy_cnt_d = busy_cnt_q + ToW'(1);
        if ((TIMEOUT_CYCLES != 0) && (busy_cnt_q == ToLast)) timeout_d = 1'b1;
        if (port1_sent_i || port2_sent_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Clear takes precedence over any same-cycle increment or timeout set.
    if (clear_i) begin
      p1_cnt_d  = '0;
      p2_cnt_d  = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= StIdle;
      sel_q      <= 1'b1;
      burst_q    <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
      p1_cnt_q   <= '0;
      p2_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      burst_q    <= burst_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
      p1_cnt_q   <= p1_cnt_d;
      p2_cnt_q   <= p2_cnt_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign port1_cnt_o = p1_cnt_q;
  assign port2_cnt_o = p2_cnt_q;

endmodule

// File: tb/tb_rab_lookup_arbiter.sv
// Bench for rab_lookup_arbiter. Two instances share all stimulus: one with
// 8-bit counters, one with 2-bit counters to exercise saturation.

module tb_rab_lookup_arbiter;

  localparam int unsigned W = 2;
  localparam int unsigned T = 8;

  logic       clk, rst_n;
  logic       p1v, p2v, p1s, p2s, inv, clr;
  logic       sel, launch, busy, to;
  logic [7:0] c1, c2;
  logic       sel_n, launch_n, busy_n, to_n;
  logic [1:0] c1n, c2n;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic p1v, p2v, p1s, p2s, inv, clr;
    logic e_sel, e_launch, e_busy, e_to;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  // Expected counter values, derived from the table's expected launches.
  int unsigned m1, m2, m1n, m2n;

  rab_lookup_arbiter #(.PORT1_WEIGHT(W), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .port1_addr_valid_i(p1v), .port2_addr_valid_i(p2v),
    .port1_sent_i(p1s), .port2_sent_i(p2s),
    .invalidate_i(inv), .clear_i(clr),
    .select_o(sel), .launch_o(launch), .busy_o(busy), .timeout_o(to),
    .port1_cnt_o(c1), .port2_cnt_o(c2)
  );

  rab_lookup_arbiter #(.PORT1_WEIGHT(W), .TIMEOUT_CYCLES(T), .CNT_WIDTH(2)) dut_n (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .port1_addr_valid_i(p1v), .port2_addr_valid_i(p2v),
    .port1_sent_i(p1s), .port2_sent_i(p2s),
    .invalidate_i(inv), .clear_i(clr),
    .select_o(sel_n), .launch_o(launch_n), .busy_o(busy_n), .timeout_o(to_n),
    .port1_cnt_o(c1n), .port2_cnt_o(c2n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  function automatic void add(input logic a_p1v, input logic a_p2v, input logic a_p1s,
                              input logic a_p2s, input logic a_inv, input logic a_clr,
                              input logic a_sel, input logic a_launch, input logic a_busy,
                              input logic a_to);
    vec_t v;
    v.p1v = a_p1v; v.p2v = a_p2v; v.p1s = a_p1s; v.p2s = a_p2s;
    v.inv = a_inv; v.clr = a_clr;
    v.e_sel = a_sel; v.e_launch = a_launch; v.e_busy = a_busy; v.e_to = a_to;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk); #1;
    p1v = v.p1v; p2v = v.p2v; p1s = v.p1s; p2s = v.p2s; inv = v.inv; clr = v.clr;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("select",    idx, 32'(sel),      32'(e.e_sel));
    chk("launch",    idx, 32'(launch),   32'(e.e_launch));
    chk("busy",      idx, 32'(busy),     32'(e.e_busy));
    chk("timeout",   idx, 32'(to),       32'(e.e_to));
    chk("select_n",  idx, 32'(sel_n),    32'(e.e_sel));
    chk("launch_n",  idx, 32'(launch_n), 32'(e.e_launch));
    chk("p1_cnt",    idx, 32'(c1),       m1);
    chk("p2_cnt",    idx, 32'(c2),       m2);
    chk("p1_cnt_n",  idx, 32'(c1n),      m1n);
    chk("p2_cnt_n",  idx, 32'(c2n),      m2n);
    if (e.e_launch) begin
      if (e.e_sel) begin
        m1 = sat(m1, 255); m1n = sat(m1n, 3);
      end else begin
        m2 = sat(m2, 255); m2n = sat(m2n, 3);
      end
    end
    if (e.clr) begin
      m1 = 0; m2 = 0; m1n = 0; m2n = 0;
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    p1v = 0; p2v = 0; p1s = 0; p2s = 0; inv = 0; clr = 0;
    m1 = 0; m2 = 0; m1n = 0; m2n = 0;
    #12;
    chk("rst_select",  -1, 32'(sel),    32'd1);
    chk("rst_launch",  -1, 32'(launch), 32'd0);
    chk("rst_busy",    -1, 32'(busy),   32'd0);
    chk("rst_timeout", -1, 32'(to),     32'd0);
    chk("rst_p1_cnt",  -1, 32'(c1),     32'd0);
    chk("rst_p2_cnt",  -1, 32'(c2),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (5) add(0,0,0,0,0,0, 1,0,0,0);
    // Contended weighted round-robin, weight 2: grants 1,1,2,1,1,2.
    repeat (2) begin
      add(1,1,0,0,0,0, 1,1,0,0);
      add(1,1,1,0,0,0, 1,0,1,0);
      add(1,1,0,0,0,0, 1,1,0,0);
      add(1,1,1,0,0,0, 1,0,1,0);
      add(1,1,0,0,0,0, 0,1,0,0);
      add(1,1,0,1,0,0, 0,0,1,0);
    end
    add(0,0,0,0,0,0, 1,0,0,0);
    add(0,0,1,1,0,0, 1,0,0,0);   // sent while idle is ignored
    // Port2 alone; selection held through BUSY despite port1 valid.
    add(0,1,0,0,0,0, 0,1,0,0);
    add(1,0,0,0,0,0, 0,0,1,0);
    add(1,0,0,0,0,0, 0,0,1,0);
    add(1,0,0,1,0,0, 0,0,1,0);
    add(1,0,0,0,0,0, 1,1,0,0);
    add(0,0,1,0,0,0, 1,0,1,0);
    // Invalidate blocks launches in IDLE, ignored in BUSY.
    repeat (4) add(1,0,0,0,1,0, 1,0,0,0);
    add(1,0,0,0,0,0, 1,1,0,0);
    add(1,0,1,0,1,0, 1,0,1,0);
    add(1,0,0,0,1,0, 1,0,0,0);
    add(1,0,0,0,0,0, 1,1,0,0);   // uncontended launch, burst saturates at 2
    add(0,0,1,0,0,0, 1,0,1,0);
    add(1,1,0,0,0,0, 0,1,0,0);   // burst exhausted -> port2
    add(1,1,0,1,0,0, 0,0,1,0);
    // Timeout after 8 BUSY cycles, clear, then complete.
    add(1,0,0,0,0,0, 1,1,0,0);
    repeat (8) add(0,0,0,0,0,0, 1,0,1,0);
    add(0,0,0,0,0,0, 1,0,1,1);
    add(0,0,0,0,0,1, 1,0,1,1);
    add(0,0,1,0,0,0, 1,0,1,0);
    add(0,0,0,0,0,0, 1,0,0,0);
    // Five port1 lookups saturate the 2-bit counter; clear beats a launch.
    repeat (5) begin
      add(1,0,0,0,0,0, 1,1,0,0);
      add(0,0,1,0,0,0, 1,0,1,0);
    end
    add(1,0,0,0,0,1, 1,1,0,0);
    add(0,0,1,0,0,0, 1,0,1,0);
    add(0,0,0,0,0,0, 1,0,0,0);
    run_vecs();

    // Reset asserted mid-lookup.
    @(posedge clk); #1;
    p1v = 1; p2v = 0; p1s = 0; p2s = 0; inv = 0; clr = 0;
    @(negedge clk);
    chk("mid_launch", -2, 32'(launch), 32'd1);
    @(posedge clk); #1;
    p1v = 0;
    #2;
    chk("mid_busy_pre", -2, 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy",    -2, 32'(busy),   32'd0);
    chk("mid_select",  -2, 32'(sel),    32'd1);
    chk("mid_p1_cnt",  -2, 32'(c1),     32'd0);
    chk("mid_p1_cnt_n",-2, 32'(c1n),    32'd0);
    chk("mid_timeout", -2, 32'(to),     32'd0);
    m1 = 0; m2 = 0; m1n = 0; m2n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // Burst was reset: contended request goes to port1 twice, then port2.
    add(1,1,0,0,0,0, 1,1,0,0);
    add(1,1,1,0,0,0, 1,0,1,0);
    add(1,1,0,0,0,0, 1,1,0,0);
    add(1,1,1,0,0,0, 1,0,1,0);
    add(1,1,0,0,0,0, 0,1,0,0);
    add(0,0,0,1,0,0, 0,0,1,0);
    add(0,0,0,0,0,0, 1,0,0,0);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
